cdc_hs_tx: RTL and testbench

CDC_HS_TX -- requirements
Module: cdc_hs_tx

---
 rtl/cdc_hs_tx.sv | 120 ++++++++++++
 tb/tb_cdc_hs_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_tx.sv
// Source-side four-phase handshake transmitter: registers a word and drives req_out toward an async domain.
// Optional handshake timeout is built when CDC_HS_TIMEOUT_EN is defined.
module cdc_hs_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_f,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_out,
    input  logic                  ack_in,
    output logic                  done_out,
    output logic                  err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   accept;
    logic                   timeout;

    // ack_in is only ever observed through this synchroniser
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ready_out = (state == IDLE) && !ack_s;
    assign accept    = valid_in && ready_out;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] to_cnt;
    logic             enter_wait;

    assign enter_wait = (state == REQ) && ack_s && !timeout;
    // Fires on the cycle whose closing edge brings the count to TIMEOUT_CYCLES-1
    assign timeout    = (state != IDLE) && (to_cnt == CNT_LAST);

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept || enter_wait) begin
            to_cnt <= '0;
        end else if (state != IDLE) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            err_out <= 1'b0;
        end else begin
            err_out <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_out = 1'b0;
`endif

    // Handshake FSM; timeout wins over a same-cycle ack_s change
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_out <= data_in;
                        req_out  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        req_out <= 1'b0;
                        state   <= IDLE;
                    end else if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (!ack_s) begin
                        done_out <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx (SYNC_STAGES=2, TIMEOUT_CYCLES=16); timeout checks follow CDC_HS_TIMEOUT_EN.
module tb_cdc_hs_tx;

    logic       clk_f    = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ack_in   = 1'b0;
    logic       ready_out;
    logic [7:0] data_out;
    logic       req_out;
    logic       done_out;
    logic       err_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned ack_dly;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[4];

    cdc_hs_tx #(
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_f    (clk_f),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .req_out  (req_out),
        .ack_in   (ack_in),
        .done_out (done_out),
        .err_out  (err_out)
    );

    always #5 clk_f = ~clk_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic do_accept(input logic [7:0] d);
        chk("pre_ready", ready_out, 1);
        data_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("acc_data", data_out, d);
        chk("acc_req", req_out, 1);
        chk("acc_done", done_out, 0);
    endtask

    // Ack rise/fall with exact latency checks; returns right after the done edge
    task automatic ack_cycle(input logic [7:0] d);
        ack_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("req_hold", req_out, 1);
            chk("data_hold", data_out, d);
            chk("busy_req", ready_out, 0);
        end
        tick();
        chk("req_fall", req_out, 0);
        chk("busy_wait", ready_out, 0);
        ack_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("no_early_done", done_out, 0);
            chk("ready_low", ready_out, 0);
            chk("data_wait", data_out, d);
        end
        tick();
        chk("done_pulse", done_out, 1);
        chk("ready_back", ready_out, 1);
        chk("data_kept", data_out, d);
        chk("no_err", err_out, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 5, 8'hA5};
        vecs[1] = '{8'h00, 1, 8'h00};
        vecs[2] = '{8'hFF, 0, 8'hFF};
        vecs[3] = '{8'h96, 3, 8'h96};

        // Reset values
        @(posedge clk_f);
        @(posedge clk_f);
        #1;
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_ready", ready_out, 1);
        #3 rst_n = 1'b1;
        tick();

        // Table of single transfers
        for (int i = 0; i < 4; i++) begin
            do_accept(vecs[i].data);
            for (int k = 0; k < int'(vecs[i].ack_dly); k++) begin
                tick();
                chk("wait_req", req_out, 1);
                chk("wait_ready", ready_out, 0);
            end
            ack_cycle(vecs[i].exp_data);
            tick();
            chk("done_single", done_out, 0);
        end

        // Backpressure: 0x22 waits until the 0x11 handshake completes
        do_accept(8'h11);
        data_in  = 8'h22;
        valid_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_ready", ready_out, 0);
            chk("bp_data", data_out, 8'h11);
        end
        ack_cycle(8'h11);
        tick();
        chk("bp_accept_data", data_out, 8'h22);
        chk("bp_accept_req", req_out, 1);
        chk("bp_done_single", done_out, 0);
        valid_in = 1'b0;
        ack_cycle(8'h22);
        tick();

        // Stale ack blocks acceptance in IDLE
        ack_in = 1'b1;
        tick();
        tick();
        chk("stale_ready", ready_out, 0);
        data_in  = 8'h5A;
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stale_noreq", req_out, 0);
            chk("stale_nocap", data_out, 8'h22);
            chk("stale_nodone", done_out, 0);
        end
        ack_in = 1'b0;
        tick();
        chk("stale_rel1", ready_out, 0);
        tick();
        chk("stale_rel2", ready_out, 1);
        chk("stale_rel2_req", req_out, 0);
        tick();
        chk("stale_acc_req", req_out, 1);
        chk("stale_acc_data", data_out, 8'h5A);
        valid_in = 1'b0;
        ack_cycle(8'h5A);
        tick();

        // Reset in the middle of REQ
        do_accept(8'h3C);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_req", req_out, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_done", done_out, 0);
        chk("mrst_err", err_out, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("mrst_hold_done", done_out, 0);
            chk("mrst_hold_err", err_out, 0);
        end
        #3 rst_n = 1'b1;
        tick();
        chk("mrst_ready", ready_out, 1);
        chk("mrst_post_req", req_out, 0);
        chk("mrst_post_done", done_out, 0);

`ifdef CDC_HS_TIMEOUT_EN
        // Timeout with ack never raised
        do_accept(8'hC3);
        for (int k = 1; k < 15; k++) begin
            tick();
            chk("to_pre_err", err_out, 0);
            chk("to_pre_req", req_out, 1);
        end
        tick();
        chk("to_err", err_out, 1);
        chk("to_req", req_out, 0);
        chk("to_done", done_out, 0);
        chk("to_ready", ready_out, 1);
        tick();
        chk("to_err_single", err_out, 0);
        chk("to_done_after", done_out, 0);
`else
        // No timeout: handshake waits indefinitely
        do_accept(8'hC3);
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("nto_req", req_out, 1);
            chk("nto_err", err_out, 0);
        end
        ack_cycle(8'hC3);
        tick();
        chk("nto_done_single", done_out, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
